// File: rtl/div_16x8_seq.sv
// Iterative restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Valid/ready on both sides; divide-by-zero is flagged rather than iterated.
module div_16x8_seq #(
   parameter int unsigned DW = 16,
   parameter int unsigned VW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dz,
   output logic          ovf
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] d_q;      // dividend bits leave at the MSB, quotient bits enter at the LSB
   logic [VW-1:0] v_q;
   logic [VW:0]   p_q;
   logic [CW-1:0] cnt_q;

   logic          accept_c, last_c, dz_load_c, hs_c;
   logic [VW:0]   p_sh_c, p_nxt_c;
   logic          q_bit_c;
   logic [DW-1:0] d_nxt_c;

   // One restoring step
   always_comb begin
      p_sh_c  = {p_q[VW-1:0], d_q[DW-1]};
      q_bit_c = (p_sh_c >= {1'b0, v_q});
      p_nxt_c = q_bit_c ? (p_sh_c - {1'b0, v_q}) : p_sh_c;
      d_nxt_c = {d_q[DW-2:0], q_bit_c};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and datapath strobes
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      dz_load_c = 1'b0;
      hs_c      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_c  = 1'b1;
               state_nxt = (divisor == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == CW'(DW - 1)) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // out_valid still low here only on the divide-by-zero path
            if (!out_valid) begin
               dz_load_c = 1'b1;
            end else if (out_ready) begin
               hs_c      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q       <= '0;
         v_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dz        <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         in_ready <= (state_nxt == IDLE);

         if (accept_c) begin
            d_q   <= dividend;
            v_q   <= divisor;
            p_q   <= '0;
            cnt_q <= '0;
         end else if (state == BUSY) begin
            d_q   <= d_nxt_c;
            p_q   <= p_nxt_c;
            cnt_q <= cnt_q + CW'(1);
         end

         // Result registers move only on the edge that raises out_valid
         if (last_c) begin
            out_valid <= 1'b1;
            quotient  <= d_nxt_c;
            remainder <= p_nxt_c[VW-1:0];
            dz        <= 1'b0;
            ovf       <= |d_nxt_c[DW-1:VW];
         end else if (dz_load_c) begin
            out_valid <= 1'b1;
            quotient  <= '1;
            remainder <= d_q[VW-1:0];
            dz        <= 1'b1;
            ovf       <= 1'b1;
         end else if (hs_c) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: arithmetic reference model with a per-cycle
// compare of handshake and result outputs, directed cases and a randomized sweep.
module tb_div_16x8_seq;

   localparam int DW = 16;
   localparam int VW = 8;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] dividend  = '0;
   logic [VW-1:0] divisor   = '0;
   logic          in_ready, out_valid, dz, ovf;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [DW-1:0] dvd;
      logic [VW-1:0] dvs;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dz;
      logic          ovf;
      int            acc;
   } exp_t;

   exp_t          mq[$];
   logic [DW-1:0] last_q;
   logic [VW-1:0] last_r;
   logic          last_dz, last_ovf;

   div_16x8_seq #(.DW(DW), .VW(VW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .dz(dz), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input int acc);
      exp_t e;
      e.dvd = a;
      e.dvs = b;
      e.acc = acc;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a[VW-1:0];
         e.dz  = 1'b1;
         e.ovf = 1'b1;
      end else begin
         e.q   = a / {8'h00, b};
         e.r   = 8'(a % {8'h00, b});
         e.dz  = 1'b0;
         e.ovf = (e.q > 16'h00FF);
      end
      return e;
   endfunction

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", 32'(out_valid), 32'(0));
         chk("rst_quotient",  32'(quotient),  32'(0));
         chk("rst_remainder", 32'(remainder), 32'(0));
         chk("rst_dz",        32'(dz),        32'(0));
         chk("rst_ovf",       32'(ovf),       32'(0));
         chk("rst_in_ready",  32'(in_ready),  32'(1));
         mq.delete();
      end else begin
         logic busy, exp_ov;
         busy   = (mq.size() != 0);
         exp_ov = 1'b0;
         if (busy) exp_ov = (cyc >= mq[0].acc + (mq[0].dz ? 1 : DW));
         chk("in_ready",  32'(in_ready),  32'(!busy));
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         if (out_valid && busy) begin
            chk("quotient",  32'(quotient),  32'(mq[0].q));
            chk("remainder", 32'(remainder), 32'(mq[0].r));
            chk("dz",        32'(dz),        32'(mq[0].dz));
            chk("ovf",       32'(ovf),       32'(mq[0].ovf));
            if (out_ready) begin
               last_q   = quotient;
               last_r   = remainder;
               last_dz  = dz;
               last_ovf = ovf;
               if (mq[0].dvs != '0) begin
                  chk("recon", 32'(quotient) * 32'(mq[0].dvs) + 32'(remainder), 32'(mq[0].dvd));
                  chk("rem_lt_dvs", 32'(remainder < mq[0].dvs), 32'(1));
               end
               void'(mq.pop_front());
            end
         end
         if (in_valid && in_ready) mq.push_back(model(dividend, divisor, cyc + 1));
      end
   end

   task automatic clr_last();
      last_q   = 'x;
      last_r   = 'x;
      last_dz  = 1'bx;
      last_ovf = 1'bx;
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      do begin @(negedge clk); n++; end while (!in_ready && n < 100);
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((mq.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
      chk({name, "_idle_timeout"}, 32'(mq.size() == 0 && !out_valid), 32'(1));
   endtask

   task automatic lit(input string name, input logic [DW-1:0] q, input logic [VW-1:0] r,
                      input logic edz, input logic eovf);
      chk({name, "_q"},   32'(last_q),   32'(q));
      chk({name, "_r"},   32'(last_r),   32'(r));
      chk({name, "_dz"},  32'(last_dz),  32'(edz));
      chk({name, "_ovf"}, 32'(last_ovf), 32'(eovf));
   endtask

   initial begin
      int n;
      clr_last();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      clr_last(); send(16'h3A2C, 8'h7B); wait_idle("t1"); lit("t1", 16'h0079, 8'h09, 1'b0, 1'b0);
      clr_last(); send(16'hFE01, 8'hFF); wait_idle("t2"); lit("t2", 16'h00FF, 8'h00, 1'b0, 1'b0);
      clr_last(); send(16'hFFFF, 8'h01); wait_idle("t3"); lit("t3", 16'hFFFF, 8'h00, 1'b0, 1'b1);
      clr_last(); send(16'h1234, 8'h00); wait_idle("t4"); lit("t4", 16'hFFFF, 8'h34, 1'b1, 1'b1);

      // Backpressure with a second request held high through BUSY and DONE
      out_ready = 1'b0;
      clr_last();
      send(16'h0100, 8'h10);
      in_valid = 1'b1;
      dividend = 16'h7FFF;
      divisor  = 8'h03;
      n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      chk("t5_out_valid_seen", 32'(out_valid), 32'(1));
      repeat (5) @(negedge clk);
      chk("t5_in_ready_bp", 32'(in_ready), 32'(0));
      chk("t5_held_valid",  32'(out_valid), 32'(1));
      @(posedge clk); #1 out_ready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 20);
      chk("t5_second_accept", 32'(in_ready), 32'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      lit("t5a", 16'h0010, 8'h00, 1'b0, 1'b0);
      wait_idle("t5");
      lit("t5b", 16'h2AAA, 8'h01, 1'b0, 1'b1);

      // Reset on the 7th BUSY cycle aborts the operation
      clr_last();
      send(16'h3A2C, 8'h7B);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_out_valid", 32'(out_valid), 32'(0));
      chk("t6_async_quotient",  32'(quotient),  32'(0));
      chk("t6_async_remainder", 32'(remainder), 32'(0));
      chk("t6_async_dz_ovf",    32'({dz, ovf}), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t6_in_ready_after", 32'(in_ready), 32'(1));
      clr_last(); send(16'h00C8, 8'h0A); wait_idle("t6"); lit("t6", 16'h0014, 8'h00, 1'b0, 1'b0);

      // Randomized sweep with random gaps and random consumer backpressure
      for (int i = 0; i < 60; i++) begin
         logic [DW-1:0] a;
         logic [VW-1:0] b;
         a = 16'($urandom);
         case ($urandom_range(0, 5))
            0:       b = 8'h00;
            1:       b = 8'h01;
            2:       b = 8'($urandom_range(2, 15));
            default: b = 8'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0 && b != '0) a = 16'(b) * 16'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(a, b);
         n = 0;
         while ((mq.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            n++;
         end
         out_ready = 1'b1;
         wait_idle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
